cby_param_cfg: RTL

// - Parametrised Y-direction connection block, successor to the fixed-size cby tiles.
// - Passes W vertical tracks straight through in both directions.
// - Drives N_IPIN grid input pins through per-pin binary-select muxes.
// - Owns a configuration shift chain with a load-tracking FSM that gates ipins during (re)programming and flags short or long loads.

---
 rtl/cby_param_cfg.sv | 106 ++++++++++
 1 files changed

// File: rtl/cby_param_cfg.sv
// Parametrised Y-direction connection block: vertical track feedthroughs, per-pin
// binary-select input muxes and a configuration shift chain with a load-tracking FSM.
module cby_param_cfg #(
  parameter int W      = 9,
  parameter int N_IPIN = 11,
  parameter int TAPS   = 3
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              ccff_en,
  input  logic              ccff_head,
  input  logic [W-1:0]      chany_bottom_in,
  input  logic [W-1:0]      chany_top_in,
  output logic [W-1:0]      chany_top_out,
  output logic [W-1:0]      chany_bottom_out,
  output logic [N_IPIN-1:0] ipin_out,
  output logic              ccff_tail,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int SEL_W = ($clog2(2*TAPS) < 1) ? 1 : $clog2(2*TAPS);
  localparam int L     = N_IPIN * SEL_W;
  localparam int CW    = $clog2(L + 2);
  localparam logic [CW-1:0]  COUNT_L   = CW'(L);
  localparam logic [CW-1:0]  COUNT_MAX = CW'(L + 1);
  localparam logic [SEL_W:0] N_IN      = (SEL_W + 1)'(2 * TAPS);

  typedef enum logic [1:0] {UNCFG, LOADING, ACTIVE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_err;
  logic [L-1:0]       r_chain;
  logic [N_IPIN-1:0]  w_mux;

  assign chany_top_out    = chany_bottom_in;
  assign chany_bottom_out = chany_top_in;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_chain <= '0;
    end else if (ccff_en) begin
      r_chain[0] <= ccff_head;
      for (int k = 1; k < L; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
    end
  end

  // A load is one contiguous ccff_en burst; only a burst of exactly L bits activates the pins.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state <= UNCFG;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        UNCFG, ACTIVE: begin
          if (ccff_en) begin
            r_state <= LOADING;
            r_count <= CW'(1);
            r_err   <= 1'b0;
          end
        end
        LOADING: begin
          if (ccff_en) begin
            if (r_count != COUNT_MAX) begin
              r_count <= r_count + 1'b1;
            end
          end else if (r_count == COUNT_L) begin
            r_state <= ACTIVE;
          end else begin
            r_state <= UNCFG;
            r_err   <= 1'b1;
          end
        end
        default: r_state <= UNCFG;
      endcase
    end
  end

  for (genvar p = 0; p < N_IPIN; p++) begin : g_pin
    logic [SEL_W-1:0]  w_sel;
    logic [2*TAPS-1:0] w_in;

    // The lowest chain bit of each pin's field is the select MSB.
    for (genvar k = 0; k < SEL_W; k++) begin : g_selbit
      assign w_sel[SEL_W-1-k] = r_chain[p*SEL_W + k];
    end

    for (genvar j = 0; j < TAPS; j++) begin : g_tap
      localparam int T = (p + j * (W / TAPS)) % W;
      assign w_in[2*j]   = chany_bottom_in[T];
      assign w_in[2*j+1] = chany_top_in[T];
    end

    assign w_mux[p] = ({1'b0, w_sel} < N_IN) ? w_in[w_sel] : 1'b0;
  end

  assign cfg_done  = (r_state == ACTIVE);
  assign cfg_err   = r_err;
  assign ccff_tail = r_chain[L-1];
  assign ipin_out  = w_mux & {N_IPIN{cfg_done}};

endmodule
